// File: rtl/sd_xfer_arb.sv
// Two-requester block arbiter/sequencer in front of the single sd_controller.
// Grants one whole block per request, routes the byte handshakes to the owner and reports done/err.
module sd_xfer_arb #(
    parameter int BLOCKSIZE     = 512,
    parameter int START_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    input  logic        r1_req,
    input  logic        r0_wr,
    input  logic        r1_wr,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r1_addr,
    output logic        r0_grant,
    output logic        r1_grant,
    output logic        r0_done,
    output logic        r1_done,
    output logic        r0_err,
    output logic        r1_err,
    input  logic [7:0]  r0_din,
    input  logic [7:0]  r1_din,
    input  logic        r0_din_valid,
    input  logic        r1_din_valid,
    output logic        r0_din_taken,
    output logic        r1_din_taken,
    output logic [7:0]  r0_dout,
    output logic [7:0]  r1_dout,
    output logic        r0_dout_avail,
    output logic        r1_dout_avail,
    input  logic        r0_dout_taken,
    input  logic        r1_dout_taken,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic [31:0] sd_addr,
    input  logic        sd_busy,
    input  logic        sd_error,
    input  logic [2:0]  sd_error_code,
    output logic [7:0]  sd_din,
    output logic        sd_din_valid,
    input  logic        sd_din_taken,
    input  logic [7:0]  sd_dout,
    input  logic        sd_dout_avail,
    output logic        sd_dout_taken,
    output logic [2:0]  last_err_code,
    output logic [2:0]  arb_state
);

    localparam int CW = (BLOCKSIZE > 1) ? $clog2(BLOCKSIZE) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(BLOCKSIZE - 1);
    localparam logic [31:0]   TMO_LAST  = 32'(START_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAITRDY = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_XFER    = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERR     = 3'd6;

    logic [2:0]    state;
    logic          owner;
    logic          last;
    logic          wr_q;
    logic          err_q;
    logic          hs_prev;
    logic [31:0]   addr_q;
    logic [CW-1:0] byte_cnt;
    logic [31:0]   tmo_cnt;

    logic route, owns, cmd, pick, hs, hs_edge, hs_idle, tmo_hit;

    // Both requesting: the one that did not win last time goes next.
    assign pick    = (r0_req && r1_req) ? ~last : r1_req;
    assign route   = (state == S_XFER) || (state == S_DRAIN);
    assign owns    = (state != S_IDLE) && (state != S_DONE);
    assign cmd     = (state == S_START) || (state == S_XFER);
    assign hs      = wr_q ? sd_din_taken : sd_dout_taken;
    assign hs_edge = hs && !hs_prev;
    assign hs_idle = wr_q ? !(sd_din_valid || sd_din_taken) : !(sd_dout_avail || sd_dout_taken);
    assign tmo_hit = (START_TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

    assign sd_rd     = cmd && !wr_q;
    assign sd_wr     = cmd && wr_q;
    assign sd_addr   = addr_q;
    assign arb_state = state;

    assign r0_grant = owns && !owner;
    assign r1_grant = owns && owner;
    assign r0_done  = (state == S_DONE) && !owner;
    assign r1_done  = (state == S_DONE) && owner;
    assign r0_err   = r0_done && err_q;
    assign r1_err   = r1_done && err_q;

    assign sd_din        = route ? (owner ? r1_din : r0_din) : 8'h00;
    assign sd_din_valid  = route && (owner ? r1_din_valid : r0_din_valid);
    assign sd_dout_taken = route && (owner ? r1_dout_taken : r0_dout_taken);

    assign r0_din_taken  = route && !owner && sd_din_taken;
    assign r1_din_taken  = route && owner && sd_din_taken;
    assign r0_dout_avail = route && !owner && sd_dout_avail;
    assign r1_dout_avail = route && owner && sd_dout_avail;
    assign r0_dout       = (route && !owner) ? sd_dout : 8'h00;
    assign r1_dout       = (route && owner) ? sd_dout : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            owner         <= 1'b0;
            last          <= 1'b1;
            wr_q          <= 1'b0;
            err_q         <= 1'b0;
            hs_prev       <= 1'b0;
            addr_q        <= 32'h0;
            byte_cnt      <= '0;
            tmo_cnt       <= 32'h0;
            last_err_code <= 3'b000;
        end else begin
            hs_prev <= hs;
            case (state)
                S_IDLE: begin
                    if (r0_req || r1_req) begin
                        owner    <= pick;
                        last     <= pick;
                        wr_q     <= pick ? r1_wr : r0_wr;
                        addr_q   <= pick ? r1_addr : r0_addr;
                        byte_cnt <= '0;
                        tmo_cnt  <= 32'h0;
                        err_q    <= 1'b0;
                        state    <= S_WAITRDY;
                    end
                end
                S_WAITRDY: if (!sd_busy) state <= S_START;
                S_START: begin
                    if (sd_error) begin
                        last_err_code <= sd_error_code;
                        err_q         <= 1'b1;
                        tmo_cnt       <= 32'h0;
                        state         <= S_ERR;
                    end else if (sd_busy) begin
                        tmo_cnt <= 32'h0;
                        state   <= S_XFER;
                    end else if (tmo_hit) begin
                        last_err_code <= 3'b111;
                        err_q         <= 1'b1;
                        tmo_cnt       <= 32'h0;
                        state         <= S_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                S_XFER: begin
                    // Error beats a completing byte in the same cycle.
                    if (sd_error) begin
                        last_err_code <= sd_error_code;
                        err_q         <= 1'b1;
                        state         <= S_ERR;
                    end else if (hs_edge) begin
                        byte_cnt <= byte_cnt + CW'(1);
                        if (byte_cnt == LAST_BYTE) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (sd_error) begin
                        last_err_code <= sd_error_code;
                        err_q         <= 1'b1;
                        state         <= S_ERR;
                    end else if (hs_idle && !sd_busy) begin
                        state <= S_DONE;
                    end
                end
                S_ERR:   if (!sd_busy) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_xfer_arb.sv
// Directed bench for sd_xfer_arb: drives both requesters and a cycle-stepped controller model,
// with a byte scoreboard checking data through the arbiter in both directions.
module tb_sd_xfer_arb;

    localparam int BS = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req, wr, din_valid, dout_taken;
    logic [31:0] addr0, addr1;
    logic [7:0]  din0, din1;
    wire  [1:0]  grant, done, err, din_taken, dout_avail;
    wire  [7:0]  dout0, dout1;
    logic        sd_busy, sd_error, sd_din_taken, sd_dout_avail;
    logic [2:0]  sd_error_code;
    logic [7:0]  sd_dout;
    wire         sd_rd, sd_wr, sd_din_valid, sd_dout_taken;
    wire  [31:0] sd_addr;
    wire  [7:0]  sd_din;
    wire  [2:0]  last_err_code, arb_state;

    int tests = 0;
    int fails = 0;
    logic [7:0] sb[$];

    sd_xfer_arb #(.BLOCKSIZE(BS), .START_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(req[0]), .r1_req(req[1]),
        .r0_wr(wr[0]), .r1_wr(wr[1]),
        .r0_addr(addr0), .r1_addr(addr1),
        .r0_grant(grant[0]), .r1_grant(grant[1]),
        .r0_done(done[0]), .r1_done(done[1]),
        .r0_err(err[0]), .r1_err(err[1]),
        .r0_din(din0), .r1_din(din1),
        .r0_din_valid(din_valid[0]), .r1_din_valid(din_valid[1]),
        .r0_din_taken(din_taken[0]), .r1_din_taken(din_taken[1]),
        .r0_dout(dout0), .r1_dout(dout1),
        .r0_dout_avail(dout_avail[0]), .r1_dout_avail(dout_avail[1]),
        .r0_dout_taken(dout_taken[0]), .r1_dout_taken(dout_taken[1]),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_addr(sd_addr),
        .sd_busy(sd_busy), .sd_error(sd_error), .sd_error_code(sd_error_code),
        .sd_din(sd_din), .sd_din_valid(sd_din_valid), .sd_din_taken(sd_din_taken),
        .sd_dout(sd_dout), .sd_dout_avail(sd_dout_avail), .sd_dout_taken(sd_dout_taken),
        .last_err_code(last_err_code), .arb_state(arb_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; wr = '0; din_valid = '0; dout_taken = '0;
        addr0 = '0; addr1 = '0; din0 = '0; din1 = '0;
        sd_busy = 0; sd_error = 0; sd_error_code = '0;
        sd_din_taken = 0; sd_dout_avail = 0; sd_dout = '0;
        sb.delete();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        step(); step();
        rst_n = 1;
        step();
    endtask

    task automatic request(input int who, input bit w, input logic [31:0] a);
        req[who] = 1'b1;
        wr[who]  = w;
        if (who == 1) addr1 = a; else addr0 = a;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_outs"}, 32'({grant, done, err, din_taken, dout_avail,
                                 sd_rd, sd_wr, sd_din_valid, sd_dout_taken}), 0);
        chk({tag, "_data"}, 32'({dout0, dout1, sd_din}), 0);
        chk({tag, "_addr"}, sd_addr, 0);
        chk({tag, "_state"}, 32'(arb_state), 0);
        chk({tag, "_errcode"}, 32'(last_err_code), 0);
    endtask

    // One block for requester `who`; err_at/rst_at pick the byte where an error or reset hits (-1 = never).
    task automatic run_block(input int who, input bit w, input logic [31:0] a,
                             input int err_at, input int rst_at, input bit keep, input bit drop_early);
        int n;
        bit aborted;
        logic [7:0] d;
        logic [1:0] cmd_exp;
        aborted = 0;
        cmd_exp = w ? 2'b01 : 2'b10;
        n = 0;
        while (!grant[who] && n < 20) begin step(); n++; end
        chk("grant", 32'(grant[who]), 1);
        chk("grant_other", 32'(grant[1-who]), 0);
        if (drop_early) req[who] = 1'b0;
        n = 0;
        while (!(sd_rd || sd_wr) && n < 20) begin step(); n++; end
        chk("cmd", 32'({sd_rd, sd_wr}), 32'(cmd_exp));
        chk("sd_addr", sd_addr, a);
        sd_busy = 1;
        step();
        for (int i = 0; i < BS; i++) begin
            if (i == rst_at) begin
                rst_n = 0;
                #1;
                check_reset_outs("async_rst");
                clear_inputs();
                step();
                rst_n = 1;
                step();
                return;
            end
            if (i == err_at) begin
                sd_error = 1; sd_error_code = 3'd3;
                step();
                sd_error = 0;
                chk("err_cmd", 32'({sd_rd, sd_wr}), 0);
                chk("err_code", 32'(last_err_code), 3);
                dout_taken[who] = 1; din_valid[who] = 1;
                #1;
                chk("err_block", 32'({sd_dout_taken, sd_din_valid}), 0);
                dout_taken[who] = 0; din_valid[who] = 0;
                sd_busy = 0;
                step();
                chk("err_done", 32'(done[who]), 1);
                chk("err_flag", 32'(err[who]), 1);
                aborted = 1;
                break;
            end
            if (i == BS - 1) chk("cmd_held", 32'({sd_rd, sd_wr}), 32'(cmd_exp));
            d = w ? 8'hA5 : i[7:0];
            if (!w) begin
                sd_dout = d; sd_dout_avail = 1; sb.push_back(d);
                step();
                chk("dout_avail", 32'(dout_avail[who]), 1);
                chk("no_avail_other", 32'(dout_avail[1-who]), 0);
                chk("rd_byte", 32'(who == 1 ? dout1 : dout0), 32'(sb.pop_front()));
                dout_taken[who] = 1;
                step();
                sd_dout_avail = 0;
                step();
                dout_taken[who] = 0;
                step();
            end else begin
                if (who == 1) din1 = d; else din0 = d;
                din_valid[who] = 1; sb.push_back(d);
                step();
                chk("din_valid", 32'(sd_din_valid), 1);
                chk("wr_byte", 32'(sd_din), 32'(sb.pop_front()));
                sd_din_taken = 1;
                #1;
                chk("din_taken", 32'(din_taken[who]), 1);
                chk("no_taken_other", 32'(din_taken[1-who]), 0);
                step();
                din_valid[who] = 0;
                step();
                sd_din_taken = 0;
                step();
            end
        end
        if (!aborted) begin
            chk("cmd_drop", 32'({sd_rd, sd_wr}), 0);
            step();
            chk("no_early_done", 32'(done[who]), 0);
            sd_busy = 0;
            step();
            chk("done", 32'(done[who]), 1);
            chk("done_err", 32'(err[who]), 0);
            chk("grant_drop", 32'(grant[who]), 0);
        end
        if (!keep) req = '0;
        step();
        chk("done_pulse", 32'(done[who]), 0);
    endtask

    initial begin
        int n;
        clear_inputs();
        rst_n = 0;
        #1;
        check_reset_outs("reset");
        step();
        rst_n = 1;
        step();

        // r0 read of block 5, incrementing data
        request(0, 0, 32'd5);
        step();
        chk("grant_lat", 32'(grant[0]), 1);
        run_block(0, 0, 32'd5, -1, -1, 0, 0);

        // Simultaneous requests from reset alternate r0, r1, r0, r1
        do_reset();
        request(0, 0, 32'h40);
        request(1, 1, 32'h80);
        run_block(0, 0, 32'h40, -1, -1, 1, 0);
        run_block(1, 1, 32'h80, -1, -1, 1, 0);
        run_block(0, 0, 32'h40, -1, -1, 1, 0);
        run_block(1, 1, 32'h80, -1, -1, 0, 0);

        // Controller error at byte 100, then a normal r1 write of 0xA5 to 0x100
        request(0, 0, 32'h22);
        run_block(0, 0, 32'h22, 100, -1, 0, 0);
        request(1, 1, 32'h100);
        run_block(1, 1, 32'h100, -1, -1, 0, 0);

        // Start timeout: controller never goes busy
        request(0, 0, 32'h9);
        step();
        chk("tmo_grant", 32'(grant[0]), 1);
        n = 0;
        while (!sd_rd && n < 20) begin step(); n++; end
        n = 0;
        while (sd_rd && n < 100) begin n++; step(); end
        chk("tmo_cycles", n, 16);
        chk("tmo_state", 32'(arb_state), 6);
        step();
        chk("tmo_done", 32'(done[0]), 1);
        chk("tmo_err", 32'(err[0]), 1);
        chk("tmo_code", 32'(last_err_code), 7);
        req = '0;
        step();
        chk("tmo_pulse", 32'(done[0]), 0);

        // Async reset mid-read; afterwards r0 must win a tie again, then r1 completes
        request(0, 0, 32'h33);
        run_block(0, 0, 32'h33, -1, 200, 0, 0);
        request(0, 0, 32'h44);
        request(1, 0, 32'h55);
        run_block(0, 0, 32'h44, -1, -1, 1, 1);
        run_block(1, 0, 32'h55, -1, -1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sd_xfer_arb.md
Name: sd_xfer_arb

Overview:
- Two-requester arbiter and sequencer for the single sd_controller instance inside the SD peripheral.
- Requester 0 is the APB/CPU block engine; requester 1 is a boot/DMA block mover.
- Grants the controller one whole 512-byte block at a time and drives the controller's rd/wr/addr.
- Routes the byte-stream handshakes to the owner, counts bytes, detects completion, error and start timeout, and reports per-requester done/err.

Parameters:
- BLOCKSIZE, 512, bytes per block transfer; must be a power of two, max 1024.
- START_TIMEOUT, 65535, clk cycles allowed after rd/wr assert for sd_busy to rise; 0 disables the check.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- r0_req, r1_req  in  1  request one block; level, held until done
- r0_wr, r1_wr  in  1  1 = write block, 0 = read block; sampled at grant
- r0_addr, r1_addr  in  32  block address; sampled at grant
- r0_grant, r1_grant  out  1  requester owns the controller
- r0_done, r1_done  out  1  one-cycle completion pulse
- r0_err, r1_err  out  1  error flag, valid while done=1
- r0_din, r1_din  in  8  write byte
- r0_din_valid, r1_din_valid  in  1  write byte valid
- r0_din_taken, r1_din_taken  out  1  controller took byte
- r0_dout, r1_dout  out  8  read byte
- r0_dout_avail, r1_dout_avail  out  1  read byte available
- r0_dout_taken, r1_dout_taken  in  1  requester consumed byte
- sd_rd, sd_wr  out  1  controller commands
- sd_addr  out  32  controller block address
- sd_busy, sd_error  in  1  controller status
- sd_error_code  in  3  controller error code
- sd_din  out  8
- sd_din_valid  out  1
- sd_din_taken  in  1
- sd_dout  in  8
- sd_dout_avail  in  1
- sd_dout_taken  out  1
- last_err_code  out  3  code latched at last error; 3'b111 = timeout
- arb_state  out  3  FSM state, debug

Behaviour:
- Reset: all outputs 0.
  - State IDLE; byte count 0; timeout counter 0.
  - Round-robin pointer last=1, so r0 wins first.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that requester.
  - Both req: grant the requester != last.
  - On grant: latch owner, wr and addr; set last=owner; grant goes high in the next cycle; go to WAITRDY.
- WAITRDY: wait for sd_busy==0 (the controller may still be finishing init), then go to START.
- START:
  - sd_rd or sd_wr=1 per latched wr; sd_addr=latched addr.
  - Timeout counter increments each cycle.
  - sd_busy==1 -> XFER, counter cleared.
  - Counter reaches START_TIMEOUT (nonzero) -> ERR, code 3'b111.
- XFER:
  - Keep sd_rd/sd_wr asserted.
  - Owner's din/din_valid/dout_taken drive sd_*; sd_din_taken/sd_dout/sd_dout_avail go to the owner.
  - Non-owner sees din_taken=0 and dout_avail=0; its inputs are ignored.
  - Count one byte per rising edge of sd_dout_taken (read) or sd_din_taken (write), i.e. registered previous value 0, current 1.
  - When count==BLOCKSIZE-1 and the edge occurs -> DRAIN.
- DRAIN:
  - Deassert sd_rd/sd_wr.
  - Keep routing until both handshake signals return low.
  - Then wait for sd_busy==0 -> DONE.
- DONE: owner done=1, err=0 for exactly one cycle; grant dropped the same cycle; -> IDLE.
  - A requester still holding req in IDLE is re-evaluated. It wins again only if the other is not requesting.
- ERR:
  - Entered from START/XFER/DRAIN whenever sd_error==1; sd_error takes precedence over byte-count completion in the same cycle.
  - Latch sd_error_code into last_err_code.
  - Deassert sd_rd/sd_wr; block routing (sd_dout_taken=0, sd_din_valid=0).
  - Wait sd_busy==0, then pulse done=1 with err=1 for one cycle -> IDLE.
- Requester dropping req mid-transfer: ignored; the block completes and done still pulses.
- Byte count is log2(BLOCKSIZE) bits and resets to 0 at every grant.
- Async reset mid-transfer: immediate return to reset values; sd_rd/sd_wr drop asynchronously.
- Latency: req to grant is 1 cycle when the controller is idle; done follows sd_busy falling by 1 cycle.

Test Plan:
- r0 read, addr=5, controller model streams 512 bytes 0..255,0..255 -> r0 receives all bytes in order, sd_addr=5, r0_done single pulse with err=0, r1 never sees dout_avail.
- r0 and r1 requests in the same cycle from reset -> r0 granted first; on r0_done, r1 granted with r0_req still high; on r1 completion, r0 granted next (alternation over 4 blocks).
- r1 write, addr=0x100, 512 bytes 0xA5 -> controller receives 512 bytes, sd_wr deasserted after byte 512, r1_done after sd_busy falls.
- Model raises sd_error with code 3'd3 at byte 100 of a read -> sd_rd drops, r0_done with r0_err=1, last_err_code=3, next request serviced normally.
- START_TIMEOUT=16, model never asserts busy -> ERR after 16 cycles, err=1, last_err_code=3'b111.
- rst_n pulsed low at byte 200 -> all outputs 0 immediately, arb_state=IDLE, last=1; a new r1 request is granted and completes.
